// File: rtl/wash_panel_ctrl.sv
// -----------------------------------------------------------------------------
// wash_panel_ctrl
// Front-panel controller for the washing-machine FSM. Conditions the raw panel
// buttons and lid switch (2-flop synchronizer + debounce), holds the wash-mode
// selection, issues start/cancel commands to the FSM and tracks the FSM state
// to drive busy / done / error indicators and a completed-cycle counter.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   btn_start/cancel/   raw async buttons, active-high
//   btn_mode
//   lid_sw              raw async lid switch, 1 = open
//   fsm_state[2:0]      washing FSM state, 0 = IDLE
//   fsm_timer_enable    washing FSM timer_enable
//   start, cancel       commands to the FSM
//   lid                 debounced lid to the FSM, 1 = open
//   mode1/2/3           one-hot mode: Quick / Normal / Heavy
//   busy                cycle in progress
//   done_led            completion indicator
//   err_lid             one-cycle pulse: start refused, lid open
//   err_timeout         sticky: FSM failed to leave IDLE after start
//   cycles_done[7:0]    saturating completed-cycle count
// -----------------------------------------------------------------------------
module wash_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int START_PULSE     = 5,
    parameter int ARM_TIMEOUT     = 64,
    parameter int DONE_HOLD       = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_cancel,
    input  logic       btn_mode,
    input  logic       lid_sw,
    input  logic [2:0] fsm_state,
    input  logic       fsm_timer_enable,
    output logic       start,
    output logic       cancel,
    output logic       lid,
    output logic       mode1,
    output logic       mode2,
    output logic       mode3,
    output logic       busy,
    output logic       done_led,
    output logic       err_lid,
    output logic       err_timeout,
    output logic [7:0] cycles_done
);

    // Panel states
    localparam logic [2:0] ST_SELECT   = 3'd0;
    localparam logic [2:0] ST_ARM      = 3'd1;
    localparam logic [2:0] ST_WAIT_RUN = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_ABORT    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Conditioned input lanes
    localparam int IN_START  = 0;
    localparam int IN_CANCEL = 1;
    localparam int IN_MODE   = 2;
    localparam int IN_LID    = 3;
    // Lid lane starts "open" so the machine is interlocked until the switch is seen closed
    localparam logic [3:0] IN_RST_VAL = 4'b1000;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int TMR_MAX = (START_PULSE > ARM_TIMEOUT)
                           ? ((START_PULSE > DONE_HOLD) ? START_PULSE : DONE_HOLD)
                           : ((ARM_TIMEOUT > DONE_HOLD) ? ARM_TIMEOUT : DONE_HOLD);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(START_PULSE - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(ARM_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(DONE_HOLD - 1);

    // Advance the mode selection 1 -> 2 -> 3 -> 1
    function automatic logic [1:0] mode_advance(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            2'd1:    r = 2'd2;
            2'd2:    r = 2'd3;
            default: r = 2'd1;
        endcase
        return r;
    endfunction

    // One-hot decode of the mode selection; illegal codes fall back to Quick
    function automatic logic [2:0] mode_decode(input logic [1:0] m);
        logic [2:0] r;
        case (m)
            2'd1:    r = 3'b001;
            2'd2:    r = 3'b010;
            2'd3:    r = 3'b100;
            default: r = 3'b001;
        endcase
        return r;
    endfunction

    logic [3:0]      raw_s;
    logic [3:0]      sync1_r;
    logic [3:0]      sync2_r;
    logic [3:0]      stable_r;
    logic [3:0]      press_r;
    logic [DB_W-1:0] db_cnt_r [4];

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [TMR_W-1:0] tmr_r;
    logic [1:0]       mode_sel_r;
    logic [1:0]       mode_sel_nxt_s;
    logic [2:0]       mode_oh_r;
    logic             accept_start_s;
    logic             lid_reject_s;
    logic             timeout_s;
    logic             complete_s;
    logic             tmr_run_s;
    logic             fsm_idle_s;

    logic             start_r;
    logic             cancel_r;
    logic             busy_r;
    logic             done_led_r;
    logic             err_lid_r;
    logic             err_timeout_r;
    logic [7:0]       cycles_done_r;

    assign raw_s = {lid_sw, btn_mode, btn_cancel, btn_start};

    // Synchronize and debounce all four panel inputs; press_r pulses on a stable rise
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= IN_RST_VAL;
            sync2_r  <= IN_RST_VAL;
            stable_r <= IN_RST_VAL;
            press_r  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= '0;
                    press_r[i]  <= 1'b0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_cnt_r[i] <= '0;
                    stable_r[i] <= sync2_r[i];
                    press_r[i]  <= sync2_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    press_r[i]  <= 1'b0;
                end
            end
        end
    end

    assign fsm_idle_s = (fsm_state == 3'd0) && !fsm_timer_enable;

    // Panel next-state logic; cancel wins over every other event in every state
    always_comb begin
        state_nxt_s    = state_r;
        accept_start_s = 1'b0;
        lid_reject_s   = 1'b0;
        timeout_s      = 1'b0;
        complete_s     = 1'b0;
        case (state_r)
            ST_SELECT: begin
                if (press_r[IN_CANCEL]) begin
                    state_nxt_s = ST_SELECT;
                end else if (press_r[IN_START]) begin
                    if (stable_r[IN_LID]) begin
                        lid_reject_s = 1'b1;
                    end else begin
                        state_nxt_s    = ST_ARM;
                        accept_start_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_SELECT;
                end
            end
            ST_ARM: begin
                if (press_r[IN_CANCEL]) begin
                    state_nxt_s = ST_ABORT;
                end else if (tmr_r == PULSE_LAST) begin
                    state_nxt_s = ST_WAIT_RUN;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_WAIT_RUN: begin
                if (press_r[IN_CANCEL]) begin
                    state_nxt_s = ST_ABORT;
                end else if (fsm_state != 3'd0) begin
                    state_nxt_s = ST_RUN;
                end else if (tmr_r == TIMEOUT_LAST) begin
                    state_nxt_s = ST_SELECT;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_RUN;
                end
            end
            ST_RUN: begin
                if (press_r[IN_CANCEL]) begin
                    state_nxt_s = ST_ABORT;
                end else if (fsm_idle_s) begin
                    state_nxt_s = ST_DONE;
                    complete_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ABORT: begin
                if (fsm_idle_s) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_ABORT;
                end
            end
            ST_DONE: begin
                if (tmr_r == HOLD_LAST) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_SELECT;
            end
        endcase
    end

    // Mode selection only moves while the machine is not running a cycle
    always_comb begin
        mode_sel_nxt_s = mode_sel_r;
        if (press_r[IN_MODE] && ((state_r == ST_SELECT) || (state_r == ST_DONE))) begin
            mode_sel_nxt_s = mode_advance(mode_sel_r);
        end else begin
            mode_sel_nxt_s = mode_sel_r;
        end
    end

    // The shared timer only runs in the states that measure a duration
    always_comb begin
        tmr_run_s = 1'b0;
        case (state_r)
            ST_ARM, ST_WAIT_RUN, ST_DONE: tmr_run_s = 1'b1;
            default:                      tmr_run_s = 1'b0;
        endcase
    end

    // State, timer and all panel outputs; outputs are decoded from the next state
    // so start/cancel/busy/done change on the same edge as the state itself
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_SELECT;
            tmr_r         <= '0;
            mode_sel_r    <= 2'd1;
            mode_oh_r     <= 3'b001;
            start_r       <= 1'b0;
            cancel_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_led_r    <= 1'b0;
            err_lid_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            cycles_done_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s != state_r) || !tmr_run_s) begin
                tmr_r <= '0;
            end else begin
                tmr_r <= tmr_r + TMR_W'(1);
            end
            mode_sel_r <= mode_sel_nxt_s;
            mode_oh_r  <= mode_decode(mode_sel_nxt_s);
            start_r    <= (state_nxt_s == ST_ARM);
            cancel_r   <= (state_nxt_s == ST_ABORT);
            busy_r     <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_WAIT_RUN) ||
                          (state_nxt_s == ST_RUN) || (state_nxt_s == ST_ABORT);
            done_led_r <= (state_nxt_s == ST_DONE);
            err_lid_r  <= lid_reject_s;
            if (accept_start_s) begin
                err_timeout_r <= 1'b0;
            end else if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end else begin
                err_timeout_r <= err_timeout_r;
            end
            if (complete_s && (cycles_done_r != 8'd255)) begin
                cycles_done_r <= cycles_done_r + 8'd1;
            end else begin
                cycles_done_r <= cycles_done_r;
            end
        end
    end

    assign start       = start_r;
    assign cancel      = cancel_r;
    assign lid         = stable_r[IN_LID];
    assign mode1       = mode_oh_r[0];
    assign mode2       = mode_oh_r[1];
    assign mode3       = mode_oh_r[2];
    assign busy        = busy_r;
    assign done_led    = done_led_r;
    assign err_lid     = err_lid_r;
    assign err_timeout = err_timeout_r;
    assign cycles_done = cycles_done_r;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wash_panel_ctrl
// Table-driven bench for wash_panel_ctrl with short debounce (4 cycles).
// Each table row holds inputs for n cycles; its expected output word is pushed
// to a scoreboard queue when driven and popped/compared once the hold elapses.
// Output word: {start,cancel,lid,mode3,mode2,mode1,busy,done_led,err_lid,
//               err_timeout,cycles_done[7:0]}
// -----------------------------------------------------------------------------
module tb_wash_panel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_cancel = 1'b0;
    logic       btn_mode = 1'b0;
    logic       lid_sw = 1'b0;
    logic [2:0] fsm_state = 3'd0;
    logic       fsm_timer_enable = 1'b0;
    logic       start, cancel, lid, mode1, mode2, mode3;
    logic       busy, done_led, err_lid, err_timeout;
    logic [7:0] cycles_done;

    wash_panel_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .START_PULSE(5),
        .ARM_TIMEOUT(64),
        .DONE_HOLD(100)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_cancel(btn_cancel), .btn_mode(btn_mode),
        .lid_sw(lid_sw), .fsm_state(fsm_state), .fsm_timer_enable(fsm_timer_enable),
        .start(start), .cancel(cancel), .lid(lid),
        .mode1(mode1), .mode2(mode2), .mode3(mode3),
        .busy(busy), .done_led(done_led), .err_lid(err_lid),
        .err_timeout(err_timeout), .cycles_done(cycles_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        bs, bc, bm, ls;
        logic [2:0]  fs;
        logic        te;
        int          n;
        logic [17:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [17:0] sb_q[$];
    string       sb_name_q[$];
    int          total = 0;
    int          bad = 0;

    function automatic logic [17:0] E(input logic st, input logic ca, input logic ld,
                                      input logic [2:0] md, input logic bz,
                                      input logic dn, input logic el, input logic et,
                                      input logic [7:0] cyc);
        return {st, ca, ld, md, bz, dn, el, et, cyc};
    endfunction

    function automatic logic [17:0] actual();
        return {start, cancel, lid, mode3, mode2, mode1, busy, done_led,
                err_lid, err_timeout, cycles_done};
    endfunction

    task automatic add(input string nm, input logic bs, input logic bc, input logic bm,
                       input logic ls, input logic [2:0] fs, input logic te,
                       input int n, input logic [17:0] exp);
        vec_t v;
        v.name = nm; v.bs = bs; v.bc = bc; v.bm = bm; v.ls = ls;
        v.fs = fs; v.te = te; v.n = n; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic sb_check();
        logic [17:0] e;
        string       nm;
        logic [17:0] a;
        e  = sb_q.pop_front();
        nm = sb_name_q.pop_front();
        a  = actual();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got=%05h want=%05h", nm, a, e);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, a, e);
        end
    endtask

    // Called at a negedge: drive, hold n cycles, sample at the following negedge
    task automatic run_vec(input vec_t v);
        btn_start = v.bs; btn_cancel = v.bc; btn_mode = v.bm; lid_sw = v.ls;
        fsm_state = v.fs; fsm_timer_enable = v.te;
        sb_q.push_back(v.exp);
        sb_name_q.push_back(v.name);
        repeat (v.n) @(posedge clk);
        @(negedge clk);
        sb_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_hi;
        int hi_cnt;
        // name, bs bc bm lid fs te n, expected (st ca lid mode busy done el et cyc)
        add("idle",         0,0,0,0, 3'd0,0,  8, E(0,0,0,3'b001,0,0,0,0,8'd0));
        add("mode_to_2",    0,0,1,0, 3'd0,0,  8, E(0,0,0,3'b010,0,0,0,0,8'd0));
        add("mode_rel1",    0,0,0,0, 3'd0,0,  8, E(0,0,0,3'b010,0,0,0,0,8'd0));
        add("mode_to_3",    0,0,1,0, 3'd0,0,  8, E(0,0,0,3'b100,0,0,0,0,8'd0));
        add("mode_rel2",    0,0,0,0, 3'd0,0,  8, E(0,0,0,3'b100,0,0,0,0,8'd0));
        add("mode_to_1",    0,0,1,0, 3'd0,0,  8, E(0,0,0,3'b001,0,0,0,0,8'd0));
        add("mode_rel3",    0,0,0,0, 3'd0,0,  8, E(0,0,0,3'b001,0,0,0,0,8'd0));
        add("bounce_hi",    0,0,1,0, 3'd0,0,  3, E(0,0,0,3'b001,0,0,0,0,8'd0));
        add("bounce_lo",    0,0,0,0, 3'd0,0,  8, E(0,0,0,3'b001,0,0,0,0,8'd0));
        add("lid_open",     0,0,0,1, 3'd0,0,  8, E(0,0,1,3'b001,0,0,0,0,8'd0));
        add("lid_refuse",   1,0,0,1, 3'd0,0,  7, E(0,0,1,3'b001,0,0,1,0,8'd0));
        add("lid_pulse1",   1,0,0,1, 3'd0,0,  1, E(0,0,1,3'b001,0,0,0,0,8'd0));
        add("lid_rel",      0,0,0,1, 3'd0,0,  8, E(0,0,1,3'b001,0,0,0,0,8'd0));
        add("lid_close",    0,0,0,0, 3'd0,0,  8, E(0,0,0,3'b001,0,0,0,0,8'd0));
        add("run_arm",      1,0,0,0, 3'd0,0,  7, E(1,0,0,3'b001,1,0,0,0,8'd0));
        add("run_pulse5",   0,0,0,0, 3'd0,0,  4, E(1,0,0,3'b001,1,0,0,0,8'd0));
        add("run_pulseend", 0,0,0,0, 3'd0,0,  1, E(0,0,0,3'b001,1,0,0,0,8'd0));
        add("run_fsm2",     0,0,0,0, 3'd2,1,  2, E(0,0,0,3'b001,1,0,0,0,8'd0));
        add("run_modeign",  0,0,1,0, 3'd3,1,  8, E(0,0,0,3'b001,1,0,0,0,8'd0));
        add("run_fsm4",     0,0,0,0, 3'd4,1,  8, E(0,0,0,3'b001,1,0,0,0,8'd0));
        add("run_fsm5",     0,0,0,0, 3'd5,1,  3, E(0,0,0,3'b001,1,0,0,0,8'd0));
        add("run_fsm0_te",  0,0,0,0, 3'd0,1,  3, E(0,0,0,3'b001,1,0,0,0,8'd0));
        add("done_enter",   0,0,0,0, 3'd0,0,  1, E(0,0,0,3'b001,0,1,0,0,8'd1));
        add("done_hold99",  0,0,0,0, 3'd0,0, 99, E(0,0,0,3'b001,0,1,0,0,8'd1));
        add("done_exit",    0,0,0,0, 3'd0,0,  1, E(0,0,0,3'b001,0,0,0,0,8'd1));
        add("cx_arm",       1,0,0,0, 3'd0,0,  7, E(1,0,0,3'b001,1,0,0,0,8'd1));
        add("cx_wait",      0,0,0,0, 3'd0,0,  5, E(0,0,0,3'b001,1,0,0,0,8'd1));
        add("cx_run",       0,0,0,0, 3'd3,1,  2, E(0,0,0,3'b001,1,0,0,0,8'd1));
        add("cx_abort",     0,1,0,0, 3'd3,1,  7, E(0,1,0,3'b001,1,0,0,0,8'd1));
        add("cx_hold",      0,0,0,0, 3'd3,1, 10, E(0,1,0,3'b001,1,0,0,0,8'd1));
        add("cx_hold_te",   0,0,0,0, 3'd0,1,  3, E(0,1,0,3'b001,1,0,0,0,8'd1));
        add("cx_release",   0,0,0,0, 3'd0,0,  1, E(0,0,0,3'b001,0,0,0,0,8'd1));
        add("to_arm",       1,0,0,0, 3'd0,0,  7, E(1,0,0,3'b001,1,0,0,0,8'd1));
        add("to_pulse",     0,0,0,0, 3'd0,0,  4, E(1,0,0,3'b001,1,0,0,0,8'd1));
        add("to_wait",      0,0,0,0, 3'd0,0,  1, E(0,0,0,3'b001,1,0,0,0,8'd1));
        add("to_wait63",    0,0,0,0, 3'd0,0, 63, E(0,0,0,3'b001,1,0,0,0,8'd1));
        add("to_expire",    0,0,0,0, 3'd0,0,  1, E(0,0,0,3'b001,0,0,0,1,8'd1));
        add("to_clear",     1,0,0,0, 3'd0,0,  7, E(1,0,0,3'b001,1,0,0,0,8'd1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        sb_q.push_back(E(0,0,1,3'b001,0,0,0,0,8'd0));
        sb_name_q.push_back("reset_vals");
        sb_check();
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset asserted while ARM is driving start
        rst = 1'b1; btn_start = 1'b0;
        sb_q.push_back(E(0,0,1,3'b001,0,0,0,0,8'd0));
        sb_name_q.push_back("rst_in_arm");
        @(posedge clk);
        @(negedge clk);
        sb_check();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(E(0,0,1,3'b001,0,0,0,0,8'd0));
        sb_name_q.push_back("post_rst_quiet");
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb_check();
        sb_q.push_back(E(0,0,0,3'b001,0,0,0,0,8'd0));
        sb_name_q.push_back("post_rst_lid");
        repeat (6) @(posedge clk);
        @(negedge clk);
        sb_check();

        // Start latency and pulse width, edge by edge
        first_hi = 0;
        hi_cnt   = 0;
        btn_start = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 11) btn_start = 1'b0;
            if (start && (first_hi == 0)) first_hi = e;
            if (start) hi_cnt++;
        end
        check_int("start_first_edge", first_hi, 7);
        check_int("start_width", hi_cnt, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wash_panel_ctrl.md
Name: wash_panel_ctrl

Overview:
Front-panel controller that sits on the user side of the washing-machine FSM and drives its command inputs.
- Debounces raw panel inputs: start, cancel, mode buttons and the lid switch.
- Holds the one-hot wash-mode selection and issues the start and cancel commands to the FSM.
- Watches the FSM state and timer_enable to track run, completion and abort, and drives the panel indicators.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from its stable value before the stable value flips (≥1).
START_PULSE, 5, cycles the start output is held high per start command (≥1).
ARM_TIMEOUT, 64, cycles to wait for FSM state to leave IDLE after the start pulse.
DONE_HOLD, 100, cycles done_led stays lit after a completed cycle.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
btn_start  in  1  raw start button, async, active-high
btn_cancel  in  1  raw cancel button, async, active-high
btn_mode  in  1  raw mode-cycle button, async, active-high
lid_sw  in  1  raw lid switch, async; 1 = open
fsm_state  in  3  FSM state; 0 = IDLE
fsm_timer_enable  in  1  FSM timer_enable
start  out  1  start command to FSM
cancel  out  1  cancel command to FSM
lid  out  1  debounced lid to FSM; 1 = open
mode1, mode2, mode3  out  1 each  one-hot mode: Quick, Normal, Heavy
busy  out  1  cycle in progress (ARM, WAIT_RUN, RUN, ABORT)
done_led  out  1  completion indicator
err_lid  out  1  one-cycle pulse: start refused because lid open
err_timeout  out  1  sticky: FSM failed to start; cleared by next accepted start
cycles_done  out  8  count of completed cycles, saturates at 255

Behaviour:
Reset values:
- start=0, cancel=0, lid=1, mode1=1, mode2=0, mode3=0.
- busy=0, done_led=0, err_lid=0, err_timeout=0, cycles_done=0.
- All debounced stable values reset to 0, except lid, which resets to 1.
- Panel state = SELECT.
- rst asserted mid-operation returns every output to these values on the next edge, with no start or cancel glitch.

Input conditioning:
- Each raw input passes through a 2-flop synchronizer, then a debounce counter.
- The counter resets whenever the synchronized value equals the stable value.
- press_x is a one-cycle pulse on the rising edge of the stable button value.
- Latency: a button held high from edge 1 produces start=1 after edge DEBOUNCE_CYCLES+3.
- A bounce shorter than DEBOUNCE_CYCLES produces no press.

Mode selection:
- 2-bit mode_sel, reset 1; press_mode advances 1→2→3→1.
- Honoured only in SELECT and DONE; ignored otherwise.
- mode outputs are always the one-hot decode of mode_sel and stay stable through a run.

Panel states:
- SELECT:
  - press_cancel has priority over press_start in the same cycle; no state change results.
  - press_start with lid=0 → ARM; err_timeout cleared.
  - press_start with lid=1 → err_lid=1 for one cycle; stay in SELECT.
- ARM:
  - start=1 for exactly START_PULSE cycles, then → WAIT_RUN.
  - press_cancel → ABORT; start drops on the same edge.
- WAIT_RUN:
  - fsm_state≠0 → RUN.
  - ARM_TIMEOUT cycles elapse with fsm_state=0 → SELECT, err_timeout=1.
  - press_cancel → ABORT.
- RUN:
  - fsm_state=0 and fsm_timer_enable=0 → DONE; cycles_done += 1 (saturating).
  - press_cancel → ABORT.
  - press_start and press_mode ignored.
- ABORT:
  - cancel=1 throughout.
  - When fsm_state=0 and fsm_timer_enable=0 → SELECT; cancel falls on that edge.
  - cycles_done unchanged.
- DONE:
  - done_led=1 for DONE_HOLD cycles, then → SELECT.
  - press_start ignored; press_mode honoured.

Other rules:
- lid output tracks the debounced lid in every state.
- busy is asserted in ARM, WAIT_RUN, RUN and ABORT.

Test Plan:
- Reset then Quick run (DEBOUNCE_CYCLES=4, START_PULSE=5): btn_start high 10 cycles → start high exactly 5 cycles, first high after edge 7; busy=1.
- Mode cycling: three clean btn_mode presses in SELECT → mode one-hot 010, 100, 001. A 3-cycle bounce → no change. A press during RUN → mode unchanged.
- Lid interlock: lid_sw=1 debounced, press start → err_lid single pulse, start stays 0, state SELECT.
- Full cycle with FSM model: fsm_state 0→2→3→4→5→0 and timer_enable falls → done_led high 100 cycles, cycles_done=1, busy=0.
- Cancel mid-RUN: press cancel while fsm_state=3 → cancel held until fsm_state=0 and timer_enable=0, then falls; cycles_done unchanged.
- Timeout and reset: FSM stub never leaves 0 → after START_PULSE+ARM_TIMEOUT cycles err_timeout=1, state SELECT. rst during ARM → start=0 on next edge, all outputs at reset values.
